// File: rtl/chess_countdown_pair_pkg.sv
// Shared chess-timer definitions: counter width, time type and player indices.
// Also imported by the chess-timer FSM that watches counter_1 / counter_2.
package chess_timer_pkg;

  localparam int TIMER_W = 10;

  typedef logic [TIMER_W-1:0] timer_t;

  localparam int P1 = 0;
  localparam int P2 = 1;

endpackage

// File: rtl/chess_countdown_pair_if.sv
// Strobes from the chess-timer FSM to the countdown pair, and the remaining-time
// values and status flags returned to the FSM.
interface chess_countdown_pair_if;
  import chess_timer_pkg::*;

  logic [1:0] load_counters;
  logic [1:0] en_counters;
  timer_t     counter_1;
  timer_t     counter_2;
  logic       tick;
  logic [1:0] expired;

  modport master (
    output load_counters, en_counters,
    input  counter_1, counter_2, tick, expired
  );

  modport slave (
    input  load_counters, en_counters,
    output counter_1, counter_2, tick, expired
  );
endinterface

// File: rtl/chess_countdown_pair_tick_prescaler.sv
// Shared prescaler: counts 0..DIV-1 while run is high and sits at 0 while idle,
// so every new turn starts with a full tick period.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick_edge,
  output logic tick
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

  logic [PW-1:0] p_q, p_d;
  logic          tick_q;

  assign tick_edge = run && (p_q == P_LAST);
  assign tick      = tick_q;

  always_comb begin
    p_d = '0;
    if (run && !tick_edge) begin
      p_d = p_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      tick_q <= tick_edge;
    end
  end

endmodule

// File: rtl/chess_countdown_pair.sv
// Dual per-player countdown for the chess timer, driven by a shared tick prescaler.
// Define SIM_FAST_TICK_EN to run the prescaler at FAST_DIV for short sims and demos.
module chess_countdown_pair
  import chess_timer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int START_VALUE = 300,
  parameter int FAST_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  chess_countdown_pair_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
`ifdef SIM_FAST_TICK_EN
  localparam int PRESC_DIV = FAST_DIV;
`else
  localparam int PRESC_DIV = DIV;
`endif
  localparam timer_t START_T = timer_t'(START_VALUE);

  if (DIV < 2) begin : g_bad_div
    $error("chess_countdown_pair: CLK_HZ / TICK_HZ must be at least 2");
  end
  if (START_VALUE > 1023 || START_VALUE < 0) begin : g_bad_start
    $error("chess_countdown_pair: START_VALUE must be in 0..1023");
  end
  if (FAST_DIV < 2) begin : g_bad_fast
    $error("chess_countdown_pair: FAST_DIV must be at least 2");
  end

  logic   run;
  logic   tick_edge;
  logic   tick;
  timer_t cnt_vec [2];

  assign run = |bus.en_counters;

  tick_prescaler #(
    .DIV (PRESC_DIV)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .tick_edge (tick_edge),
    .tick      (tick)
  );

  // Load beats enable; an expired counter parks at zero instead of wrapping.
  for (genvar i = 0; i < 2; i++) begin : g_cnt
    timer_t cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (bus.load_counters[i]) begin
        cnt_d = START_T;
      end else if (bus.en_counters[i] && tick_edge && (cnt_q != '0)) begin
        cnt_d = cnt_q - timer_t'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= START_T;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_vec[i] = cnt_q;
  end

  assign bus.counter_1 = cnt_vec[P1];
  assign bus.counter_2 = cnt_vec[P2];
  assign bus.tick      = tick;
  assign bus.expired   = {cnt_vec[P2] == '0, cnt_vec[P1] == '0};

endmodule
